// File: rtl/multisim_axi_txn_ctrl.sv
// multisim_axi_txn_ctrl: AXI transaction-level flow controller.
// Caps outstanding writes/reads, orders W behind AW, and provides a drain handshake.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   i_m_aw*/o_m_awready         : AW handshake from the manager-side bridge
//   o_s_awvalid/i_s_awready     : AW handshake towards the subordinate
//   i_m_wvalid/i_m_wlast/o_m_wready, o_s_wvalid/i_s_wready : W path
//   i_s_bvalid/o_s_bready/o_m_bvalid/i_m_bready            : B path (pass-through)
//   i_m_arvalid/o_m_arready/o_s_arvalid/i_s_arready        : AR path
//   i_s_rvalid/i_s_rlast/o_s_rready/o_m_rvalid/i_m_rready  : R path (pass-through)
//   i_drain/o_drained           : quiesce request / quiesced status
//   o_w_outstanding             : writes with AW accepted and B not yet returned
//   o_r_outstanding             : reads with AR accepted and final R not yet returned
//   o_err                       : sticky protocol error, cleared only by reset
module multisim_axi_txn_ctrl #(
    parameter int MAX_W_OUTSTANDING = 4,
    parameter int MAX_R_OUTSTANDING = 4,
    localparam int W_CNT_W = $clog2(MAX_W_OUTSTANDING + 1),
    localparam int R_CNT_W = $clog2(MAX_R_OUTSTANDING + 1)
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               i_m_awvalid,
    output logic               o_m_awready,
    output logic               o_s_awvalid,
    input  logic               i_s_awready,

    input  logic               i_m_wvalid,
    input  logic               i_m_wlast,
    output logic               o_m_wready,
    output logic               o_s_wvalid,
    input  logic               i_s_wready,

    input  logic               i_s_bvalid,
    output logic               o_s_bready,
    output logic               o_m_bvalid,
    input  logic               i_m_bready,

    input  logic               i_m_arvalid,
    output logic               o_m_arready,
    output logic               o_s_arvalid,
    input  logic               i_s_arready,

    input  logic               i_s_rvalid,
    input  logic               i_s_rlast,
    output logic               o_s_rready,
    output logic               o_m_rvalid,
    input  logic               i_m_rready,

    input  logic               i_drain,
    output logic               o_drained,
    output logic [W_CNT_W-1:0] o_w_outstanding,
    output logic [R_CNT_W-1:0] o_r_outstanding,
    output logic               o_err
);

    localparam logic [W_CNT_W-1:0] W_MAX  = W_CNT_W'(MAX_W_OUTSTANDING);
    localparam logic [R_CNT_W-1:0] R_MAX  = R_CNT_W'(MAX_R_OUTSTANDING);
    localparam logic [W_CNT_W-1:0] W_ONE  = W_CNT_W'(1);
    localparam logic [R_CNT_W-1:0] R_ONE  = R_CNT_W'(1);
    localparam logic [7:0]         WD_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DRAINED
    } state_e;

    state_e             state_q, state_d;
    logic [W_CNT_W-1:0] w_out_q, w_out_d;
    logic [W_CNT_W-1:0] w_credit_q, w_credit_d;
    logic [R_CNT_W-1:0] r_out_q, r_out_d;
    logic               aw_hold_q, aw_hold_d;
    logic               ar_hold_q, ar_hold_d;
    logic               err_q, err_d;
    logic [7:0]         wd_cnt_q, wd_cnt_d;

    logic aw_allow, ar_allow, w_allow;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_last_hs, r_last_hs;
    logic b_err, r_err, wd_err, w_starve;
    logic all_idle;

    // Channel gating: purely combinational from registered state,
    // so no cycle is added on any channel.
    always_comb begin
        aw_allow = ((state_q == ST_RUN) && (w_out_q < W_MAX)) || aw_hold_q;
        ar_allow = ((state_q == ST_RUN) && (r_out_q < R_MAX)) || ar_hold_q;
        w_allow  = (w_credit_q != '0);
    end

    assign o_s_awvalid = i_m_awvalid & aw_allow;
    assign o_m_awready = i_s_awready & aw_allow;
    assign o_s_arvalid = i_m_arvalid & ar_allow;
    assign o_m_arready = i_s_arready & ar_allow;
    assign o_s_wvalid  = i_m_wvalid & w_allow;
    assign o_m_wready  = i_s_wready & w_allow;

    assign o_m_bvalid  = i_s_bvalid;
    assign o_s_bready  = i_m_bready;
    assign o_m_rvalid  = i_s_rvalid;
    assign o_s_rready  = i_m_rready;

    assign aw_hs = o_s_awvalid & i_s_awready;
    assign w_hs  = o_s_wvalid & i_s_wready;
    assign b_hs  = i_s_bvalid & i_m_bready;
    assign ar_hs = o_s_arvalid & i_s_arready;
    assign r_hs  = i_s_rvalid & i_m_rready;

    assign w_last_hs = w_hs & i_m_wlast;
    assign r_last_hs = r_hs & i_s_rlast;

    // Responses with nothing outstanding are errors; the matching
    // decrement is suppressed so the counter saturates at zero.
    assign b_err = b_hs & (w_out_q == '0);
    assign r_err = r_last_hs & (r_out_q == '0);

    // Watchdog: W presented with no AW credit for 256 consecutive cycles.
    assign w_starve = i_m_wvalid & ~w_allow;
    assign wd_err   = w_starve & (wd_cnt_q == WD_MAX);

    assign all_idle = (w_out_q == '0) && (r_out_q == '0) &&
                      (w_credit_q == '0) && !aw_hold_q && !ar_hold_q;

    always_comb begin
        w_out_d = w_out_q;
        unique case ({aw_hs, b_hs & ~b_err})
            2'b10:   w_out_d = w_out_q + W_ONE;
            2'b01:   w_out_d = w_out_q - W_ONE;
            default: w_out_d = w_out_q;
        endcase
    end

    always_comb begin
        w_credit_d = w_credit_q;
        unique case ({aw_hs, w_last_hs})
            2'b10:   w_credit_d = w_credit_q + W_ONE;
            2'b01:   w_credit_d = w_credit_q - W_ONE;
            default: w_credit_d = w_credit_q;
        endcase
    end

    always_comb begin
        r_out_d = r_out_q;
        unique case ({ar_hs, r_last_hs & ~r_err})
            2'b10:   r_out_d = r_out_q + R_ONE;
            2'b01:   r_out_d = r_out_q - R_ONE;
            default: r_out_d = r_out_q;
        endcase
    end

    // Once a valid is presented downstream it stays allowed until it
    // is accepted, even if drain or the limit would now block it.
    always_comb begin
        aw_hold_d = aw_hold_q;
        if (aw_hs) begin
            aw_hold_d = 1'b0;
        end else if (o_s_awvalid) begin
            aw_hold_d = 1'b1;
        end

        ar_hold_d = ar_hold_q;
        if (ar_hs) begin
            ar_hold_d = 1'b0;
        end else if (o_s_arvalid) begin
            ar_hold_d = 1'b1;
        end
    end

    always_comb begin
        wd_cnt_d = 8'd0;
        if (w_starve) begin
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + 8'd1;
        end
        err_d = err_q | b_err | r_err | wd_err;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (i_drain) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!i_drain) begin
                    state_d = ST_RUN;
                end else if (all_idle) begin
                    state_d = ST_DRAINED;
                end
            end
            ST_DRAINED: begin
                if (!i_drain) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            w_out_q    <= '0;
            w_credit_q <= '0;
            r_out_q    <= '0;
            aw_hold_q  <= 1'b0;
            ar_hold_q  <= 1'b0;
            err_q      <= 1'b0;
            wd_cnt_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            w_out_q    <= w_out_d;
            w_credit_q <= w_credit_d;
            r_out_q    <= r_out_d;
            aw_hold_q  <= aw_hold_d;
            ar_hold_q  <= ar_hold_d;
            err_q      <= err_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    assign o_drained       = (state_q == ST_DRAINED);
    assign o_w_outstanding = w_out_q;
    assign o_r_outstanding = r_out_q;
    assign o_err           = err_q;

endmodule

// File: tb/tb_multisim_axi_txn_ctrl.sv
// tb_multisim_axi_txn_ctrl: directed and randomized checks of the
// transaction controller against a transaction-count reference model.
module tb_multisim_axi_txn_ctrl;

    localparam int MW = 4;
    localparam int MR = 4;
    localparam int M_RUN = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_m_awvalid = 0, i_s_awready = 0;
    logic i_m_wvalid = 0, i_m_wlast = 0, i_s_wready = 0;
    logic i_s_bvalid = 0, i_m_bready = 0;
    logic i_m_arvalid = 0, i_s_arready = 0;
    logic i_s_rvalid = 0, i_s_rlast = 0, i_m_rready = 0;
    logic i_drain = 0;
    logic o_m_awready, o_s_awvalid, o_m_wready, o_s_wvalid;
    logic o_s_bready, o_m_bvalid, o_m_arready, o_s_arvalid;
    logic o_s_rready, o_m_rvalid, o_drained, o_err;
    logic [2:0] o_w_outstanding;
    logic [2:0] o_r_outstanding;

    multisim_axi_txn_ctrl #(
        .MAX_W_OUTSTANDING(MW),
        .MAX_R_OUTSTANDING(MR)
    ) dut (
        .clk(clk), .rst(rst),
        .i_m_awvalid(i_m_awvalid), .o_m_awready(o_m_awready),
        .o_s_awvalid(o_s_awvalid), .i_s_awready(i_s_awready),
        .i_m_wvalid(i_m_wvalid), .i_m_wlast(i_m_wlast),
        .o_m_wready(o_m_wready), .o_s_wvalid(o_s_wvalid),
        .i_s_wready(i_s_wready),
        .i_s_bvalid(i_s_bvalid), .o_s_bready(o_s_bready),
        .o_m_bvalid(o_m_bvalid), .i_m_bready(i_m_bready),
        .i_m_arvalid(i_m_arvalid), .o_m_arready(o_m_arready),
        .o_s_arvalid(o_s_arvalid), .i_s_arready(i_s_arready),
        .i_s_rvalid(i_s_rvalid), .i_s_rlast(i_s_rlast),
        .o_s_rready(o_s_rready), .o_m_rvalid(o_m_rvalid),
        .i_m_rready(i_m_rready),
        .i_drain(i_drain), .o_drained(o_drained),
        .o_w_outstanding(o_w_outstanding),
        .o_r_outstanding(o_r_outstanding),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model: transaction counts and link mode.
    int m_w_out = 0, m_w_cred = 0, m_r_out = 0;
    int m_mode = M_RUN;
    bit m_aw_pend = 0, m_ar_pend = 0, m_err = 0;
    int m_starve = 0;
    int b_owed = 0;
    int dut_aw_cnt = 0;
    bit g_aw_hs, g_w_hs, g_b_hs, g_ar_hs, g_r_hs;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs set; checks the
    // cycle, advances the model across the rising edge.
    task automatic tick();
        bit aw_ok, ar_ok, w_ok, idle;
        bit e_awv, e_arv, e_wv;
        #1;
        aw_ok = (m_mode == M_RUN && m_w_out < MW) || m_aw_pend;
        ar_ok = (m_mode == M_RUN && m_r_out < MR) || m_ar_pend;
        w_ok  = (m_w_cred > 0);
        e_awv = i_m_awvalid && aw_ok;
        e_arv = i_m_arvalid && ar_ok;
        e_wv  = i_m_wvalid && w_ok;
        chk("s_awvalid", o_s_awvalid, e_awv);
        chk("m_awready", o_m_awready, i_s_awready && aw_ok);
        chk("s_arvalid", o_s_arvalid, e_arv);
        chk("m_arready", o_m_arready, i_s_arready && ar_ok);
        chk("s_wvalid", o_s_wvalid, e_wv);
        chk("m_wready", o_m_wready, i_s_wready && w_ok);
        chk("m_bvalid", o_m_bvalid, i_s_bvalid);
        chk("s_bready", o_s_bready, i_m_bready);
        chk("m_rvalid", o_m_rvalid, i_s_rvalid);
        chk("s_rready", o_s_rready, i_m_rready);
        chk("drained", o_drained, m_mode == M_DONE);
        chk("w_out", 32'(o_w_outstanding), m_w_out);
        chk("r_out", 32'(o_r_outstanding), m_r_out);
        chk("err", o_err, m_err);
        dut_aw_cnt += int'(o_s_awvalid & i_s_awready);

        g_aw_hs = e_awv && i_s_awready;
        g_ar_hs = e_arv && i_s_arready;
        g_w_hs  = e_wv && i_s_wready;
        g_b_hs  = i_s_bvalid && i_m_bready;
        g_r_hs  = i_s_rvalid && i_m_rready;

        if (rst) begin
            m_w_out = 0; m_w_cred = 0; m_r_out = 0;
            m_mode = M_RUN; m_aw_pend = 0; m_ar_pend = 0;
            m_err = 0; m_starve = 0; b_owed = 0;
        end else begin
            idle = (m_w_out == 0 && m_r_out == 0 && m_w_cred == 0 &&
                    !m_aw_pend && !m_ar_pend);
            if (g_b_hs && m_w_out == 0) m_err = 1;
            if (g_r_hs && i_s_rlast && m_r_out == 0) m_err = 1;
            m_starve = (i_m_wvalid && !w_ok) ? m_starve + 1 : 0;
            if (m_starve >= 256) m_err = 1;
            m_w_out += int'(g_aw_hs) - int'(g_b_hs && m_w_out > 0);
            m_w_cred += int'(g_aw_hs) - int'(g_w_hs && i_m_wlast);
            m_r_out += int'(g_ar_hs) -
                       int'(g_r_hs && i_s_rlast && m_r_out > 0);
            m_aw_pend = !g_aw_hs && (e_awv || m_aw_pend);
            m_ar_pend = !g_ar_hs && (e_arv || m_ar_pend);
            if (g_w_hs && i_m_wlast) b_owed++;
            if (g_b_hs && b_owed > 0) b_owed--;
            case (m_mode)
                M_RUN:   if (i_drain) m_mode = M_DRAIN;
                M_DRAIN: if (!i_drain) m_mode = M_RUN;
                         else if (idle) m_mode = M_DONE;
                default: if (!i_drain) m_mode = M_RUN;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        i_m_awvalid = 0; i_s_awready = 0;
        i_m_wvalid = 0; i_m_wlast = 0; i_s_wready = 0;
        i_s_bvalid = 0; i_m_bready = 0;
        i_m_arvalid = 0; i_s_arready = 0;
        i_s_rvalid = 0; i_s_rlast = 0; i_m_rready = 0;
        i_drain = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Reset state and post-reset gating
        chk("rst_w_out", 32'(o_w_outstanding), 0);
        chk("rst_r_out", 32'(o_r_outstanding), 0);
        chk("rst_drained", o_drained, 0);
        chk("rst_err", o_err, 0);
        i_m_wvalid = 1; i_s_wready = 1; i_m_awvalid = 1;
        #1;
        chk("rst_wvalid_blk", o_s_wvalid, 0);
        chk("rst_wready_blk", o_m_wready, 0);
        chk("rst_awvalid_pass", o_s_awvalid, 1);

        // Write limit
        do_reset();
        i_m_awvalid = 1; i_s_awready = 1;
        dut_aw_cnt = 0;
        repeat (6) tick();
        chk("lim_aw_cnt", dut_aw_cnt, 4);
        chk("lim_w_out", 32'(o_w_outstanding), 4);
        chk("lim_awready", o_m_awready, 0);
        i_s_bvalid = 1; i_m_bready = 1;
        #1;
        chk("lim_aw_with_b", o_m_awready, 0);
        tick();
        i_s_bvalid = 0;
        #1;
        chk("lim_aw_after_b", o_m_awready, 1);
        tick();
        chk("lim_w_out2", 32'(o_w_outstanding), 4);

        // W ordering behind AW
        do_reset();
        i_m_wvalid = 1; i_m_wlast = 1; i_s_wready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("word_pre_aw", o_s_wvalid, 0);
            tick();
        end
        i_m_awvalid = 1; i_s_awready = 1;
        #1;
        chk("word_same_aw", o_s_wvalid, 0);
        tick();
        i_m_awvalid = 0;
        #1;
        chk("word_after_aw", o_s_wvalid, 1);
        tick();
        #1;
        chk("word_credit0", o_s_wvalid, 0);
        i_m_wvalid = 0;
        tick();

        // Read burst
        do_reset();
        i_m_arvalid = 1; i_s_arready = 1;
        tick();
        i_m_arvalid = 0;
        for (int i = 1; i <= 4; i++) begin
            chk("rb_r_out", 32'(o_r_outstanding), 1);
            i_s_rvalid = 1; i_m_rready = 1; i_s_rlast = (i == 4);
            tick();
        end
        i_s_rvalid = 0; i_s_rlast = 0;
        chk("rb_r_out_end", 32'(o_r_outstanding), 0);

        // Drain mid-traffic
        do_reset();
        i_m_awvalid = 1; i_s_awready = 1;
        repeat (2) tick();
        i_m_awvalid = 0;
        i_m_arvalid = 1; i_s_arready = 1;
        tick();
        i_m_arvalid = 0;
        i_m_awvalid = 1; i_s_awready = 0; i_drain = 1;
        tick();
        i_s_awready = 1;
        #1;
        chk("dr_held_aw", o_s_awvalid, 1);
        tick();
        i_m_arvalid = 1; i_s_arready = 1;
        #1;
        chk("dr_new_aw_blk", o_s_awvalid, 0);
        chk("dr_new_ar_blk", o_s_arvalid, 0);
        tick();
        i_m_awvalid = 0; i_m_arvalid = 0;
        i_m_wvalid = 1; i_m_wlast = 1; i_s_wready = 1;
        repeat (3) tick();
        i_m_wvalid = 0;
        i_s_bvalid = 1; i_m_bready = 1;
        repeat (3) tick();
        i_s_bvalid = 0;
        i_s_rvalid = 1; i_m_rready = 1; i_s_rlast = 1;
        tick();
        i_s_rvalid = 0;
        chk("dr_not_yet", o_drained, 0);
        tick();
        chk("dr_drained", o_drained, 1);
        i_drain = 0;
        #1;
        chk("dr_still", o_drained, 1);
        tick();
        chk("dr_run", o_drained, 0);
        i_m_awvalid = 1; i_s_awready = 1;
        #1;
        chk("dr_aw_again", o_s_awvalid, 1);
        tick();

        // B with nothing outstanding
        do_reset();
        i_s_bvalid = 1; i_m_bready = 1;
        tick();
        i_s_bvalid = 0;
        chk("err_set", o_err, 1);
        chk("err_w_out0", 32'(o_w_outstanding), 0);
        repeat (5) tick();
        chk("err_sticky", o_err, 1);
        do_reset();
        chk("err_clr", o_err, 0);

        // Simultaneous AW and B
        i_m_awvalid = 1; i_s_awready = 1;
        repeat (2) tick();
        i_s_bvalid = 1; i_m_bready = 1;
        tick();
        chk("simul_w_out", 32'(o_w_outstanding), 2);

        // Reset in the middle of traffic
        i_m_arvalid = 1; i_s_arready = 1;
        i_m_wvalid = 1; i_s_wready = 1;
        tick();
        rst = 1;
        tick();
        rst = 0;
        idle_in();
        chk("mrst_w_out", 32'(o_w_outstanding), 0);
        chk("mrst_r_out", 32'(o_r_outstanding), 0);
        chk("mrst_err", o_err, 0);
        chk("mrst_drained", o_drained, 0);
        i_m_wvalid = 1; i_s_wready = 1;
        #1;
        chk("mrst_w_blk", o_s_wvalid, 0);

        // Watchdog: W with no AW for 256 cycles
        do_reset();
        i_m_wvalid = 1;
        repeat (255) tick();
        chk("wd_255", o_err, 0);
        tick();
        chk("wd_256", o_err, 1);
        do_reset();

        // Randomized traffic
        for (int c = 0; c < 5000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) i_drain = ~i_drain;
            if (g_aw_hs) i_m_awvalid = 0;
            if (!i_m_awvalid) i_m_awvalid = ($urandom_range(0, 2) == 0);
            if (g_ar_hs) i_m_arvalid = 0;
            if (!i_m_arvalid) i_m_arvalid = ($urandom_range(0, 2) == 0);
            if (g_w_hs) i_m_wvalid = 0;
            if (!i_m_wvalid) begin
                i_m_wvalid = ($urandom_range(0, 1) == 0);
                i_m_wlast = ($urandom_range(0, 2) == 0);
            end
            if (g_b_hs) i_s_bvalid = 0;
            if (!i_s_bvalid)
                i_s_bvalid = (b_owed > 0) && ($urandom_range(0, 1) == 0);
            if (g_r_hs) i_s_rvalid = 0;
            if (!i_s_rvalid) begin
                i_s_rvalid = (m_r_out > 0) && ($urandom_range(0, 1) == 0);
                i_s_rlast = ($urandom_range(0, 2) == 0);
            end
            i_s_awready = $urandom_range(0, 1);
            i_s_arready = $urandom_range(0, 1);
            i_s_wready = $urandom_range(0, 1);
            i_m_bready = $urandom_range(0, 1);
            i_m_rready = $urandom_range(0, 1);
            tick();
            if (rst) begin
                idle_in();
                g_aw_hs = 0; g_ar_hs = 0; g_w_hs = 0;
                g_b_hs = 0; g_r_hs = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
